// File: rtl/tdes_round_sequencer.sv
// Round/pass sequencer for a Triple-DES datapath: walks one block through three
// 16-round DES passes in EDE order and selects user key, direction and round key.
module tdes_round_sequencer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       decrypt,
    input  logic       hold,
    input  logic       abort,
    output logic       ready,
    output logic       load_block,
    output logic       round_en,
    output logic [3:0] round_num,
    output logic [3:0] key_idx,
    output logic [1:0] key_sel,
    output logic [1:0] pass_num,
    output logic       pass_dec,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       mode_q,  mode_d;
    logic [1:0] pass_q,  pass_d;
    logic [3:0] round_q, round_d;
    logic       pass_dec_s;

    // State, mode and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            pass_q  <= 2'd0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pass_q  <= pass_d;
            round_q <= round_d;
        end
    end

    // Next-state logic; abort overrides every state, including a start in IDLE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pass_d  = pass_q;
        round_d = round_q;
        if (abort) begin
            state_d = S_IDLE;
            pass_d  = 2'd0;
            round_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_d  = decrypt;
                        pass_d  = 2'd0;
                        round_d = 4'd0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    round_d = 4'd0;
                    state_d = S_ROUND;
                end
                S_ROUND: begin
                    if (hold) begin
                        state_d = S_ROUND;
                    end else if (round_q == 4'd15) begin
                        round_d = 4'd0;
                        if (pass_q < 2'd2) begin
                            pass_d  = pass_q + 2'd1;
                            state_d = S_LOAD;
                        end else begin
                            pass_d  = 2'd0;
                            state_d = S_DONE;
                        end
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    pass_d  = 2'd0;
                    round_d = 4'd0;
                end
            endcase
        end
    end

    // Moore output decode; only round_en looks at hold directly.
    always_comb begin
        ready      = (state_q == S_IDLE);
        load_block = (state_q == S_LOAD);
        round_en   = (state_q == S_ROUND) && !hold;
        done       = (state_q == S_DONE);
        round_num  = round_q;
        pass_num   = pass_q;
        key_sel    = 2'd0;
        pass_dec_s = 1'b0;
        key_idx    = 4'd0;
        if ((state_q == S_LOAD) || (state_q == S_ROUND)) begin
            // Decrypt mode reverses the key order and flips every pass direction.
            if (mode_q) begin
                key_sel    = 2'd2 - pass_q;
                pass_dec_s = (pass_q != 2'd1);
            end else begin
                key_sel    = pass_q;
                pass_dec_s = (pass_q == 2'd1);
            end
            if (pass_dec_s) begin
                key_idx = 4'd15 - round_q;
            end else begin
                key_idx = round_q;
            end
        end else begin
            key_sel    = 2'd0;
            pass_dec_s = 1'b0;
            key_idx    = 4'd0;
        end
        pass_dec = pass_dec_s;
    end

endmodule

// File: tb/tb_tdes_round_sequencer.sv
// Directed bench for tdes_round_sequencer: expected outputs come from a cycle
// timeline formula (cycle 1 = LOAD after start, 17 cycles per pass, DONE at 52).
module tb_tdes_round_sequencer;

    logic       clk = 1'b0;
    logic       n_rst, start, decrypt, hold, abort;
    logic       ready, load_block, round_en, pass_dec, done;
    logic [3:0] round_num, key_idx;
    logic [1:0] key_sel, pass_num;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [16:0] MASK_ALL  = 17'h1FFFF;
    localparam logic [16:0] MASK_PART = 17'b1_1110_0001_1111_1001;

    always #5 clk = ~clk;

    tdes_round_sequencer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .decrypt    (decrypt),
        .hold       (hold),
        .abort      (abort),
        .ready      (ready),
        .load_block (load_block),
        .round_en   (round_en),
        .round_num  (round_num),
        .key_idx    (key_idx),
        .key_sel    (key_sel),
        .pass_num   (pass_num),
        .pass_dec   (pass_dec),
        .done       (done)
    );

    // Output bundle: {ready,load,round_en,done,round_num,key_idx,key_sel,pass_num,pass_dec}
    function automatic logic [16:0] exp_out(input bit mode, input int e, input bit h);
        logic       rdy, ld, ren, dn, pd;
        logic [3:0] rn, ki;
        logic [1:0] ks, pn;
        int         p, k;
        rdy = 1'b0; ld = 1'b0; ren = 1'b0; dn = 1'b0; pd = 1'b0;
        rn = 4'd0; ki = 4'd0; ks = 2'd0; pn = 2'd0;
        if (e <= 0 || e >= 53) begin
            rdy = 1'b1;
        end else if (e == 52) begin
            dn = 1'b1;
        end else begin
            p  = (e - 1) / 17;
            k  = (e - 1) % 17;
            pn = 2'(p);
            if (k == 0) begin
                ld = 1'b1;
                rn = 4'd0;
            end else begin
                ren = !h;
                rn  = 4'(k - 1);
            end
            if (mode == 1'b0) begin
                ks = 2'(p);
                pd = (p == 1);
            end else begin
                ks = 2'(2 - p);
                pd = (p != 1);
            end
            ki = pd ? 4'(15 - int'(rn)) : rn;
        end
        return {rdy, ld, ren, dn, rn, ki, ks, pn, pd};
    endfunction

    task automatic chk(input string tag, input int c, input logic [16:0] obs, input logic [16:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%05h expected=%05h", tag, c, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int c, input bit mode, input int e,
                             input bit h, input bit full);
        logic [16:0] obs;
        logic [16:0] m;
        obs = {ready, load_block, round_en, done, round_num, key_idx, key_sel, pass_num, pass_dec};
        m   = (full || (e >= 1 && e <= 51)) ? MASK_ALL : MASK_PART;
        chk(tag, c, obs & m, exp_out(mode, e, h) & m);
    endtask

    // Drive one cycle's inputs, check that cycle's outputs, advance to the next cycle.
    task automatic cyc(input string tag, input int c, input bit st, input bit dc, input bit hd,
                       input bit ab, input bit mode, input int e);
        start = st; decrypt = dc; hold = hd; abort = ab;
        #1;
        check_out(tag, c, mode, e, hd, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; decrypt = 1'b0; hold = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_out("reset", 0, 1'b0, 0, 1'b0, 1'b1);
        n_rst = 1'b1;
        @(posedge clk); #1;
        check_out("reset_release", 0, 1'b0, 0, 1'b0, 1'b1);

        // Plain encrypt block, cycles 0..53
        for (int c = 0; c <= 53; c++) cyc("enc", c, c == 0, 1'b0, 1'b0, 1'b0, 1'b0, c);

        // Plain decrypt block
        for (int c = 0; c <= 53; c++) cyc("dec", c, c == 0, 1'b1, 1'b0, 1'b0, 1'b1, c);

        // Hold 3 cycles at pass 1 round 7 (cycles 26..28); done moves to 55
        for (int c = 0; c <= 56; c++) begin
            if (c <= 25)      cyc("hold_mid", c, c == 0, 1'b0, 1'b0, 1'b0, 1'b0, c);
            else if (c <= 28) cyc("hold_mid", c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 26);
            else              cyc("hold_mid", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c - 3);
        end

        // Hold 2 cycles at pass 2 round 15 of a decrypt block; done moves to 54
        for (int c = 0; c <= 55; c++) begin
            if (c <= 50)      cyc("hold_last", c, c == 0, 1'b1, 1'b0, 1'b0, 1'b1, c);
            else if (c <= 52) cyc("hold_last", c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 51);
            else              cyc("hold_last", c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, c - 2);
        end

        // Starts at 10 and 52 ignored with decrypt=1; start at 53 accepted, done at 105
        for (int c = 0; c <= 106; c++) begin
            if (c <= 53) cyc("start", c, (c == 0) || (c == 10) || (c == 52) || (c == 53),
                             (c != 0) && (c != 53), 1'b0, 1'b0, 1'b0, c);
            else         cyc("start", c, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c - 53);
        end

        // Abort at pass 2 round 10 (cycle 46), then abort+start together in IDLE
        for (int c = 0; c <= 50; c++) begin
            if (c <= 46) cyc("abort", c, c == 0, 1'b0, 1'b0, c == 46, 1'b0, c);
            else         cyc("abort", c, c == 47, 1'b0, 1'b0, c == 47, 1'b0, 0);
        end

        // Reset at pass 0 round 3 (cycle 5) of a decrypt block
        for (int c = 0; c <= 4; c++) cyc("rst_mid", c, c == 0, 1'b1, 1'b0, 1'b0, 1'b1, c);
        start = 1'b0; n_rst = 1'b0;
        #1;
        check_out("rst_mid", 5, 1'b1, 5, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("rst_mid_state", 6, 1'b0, 0, 1'b0, 1'b1);
        n_rst = 1'b1;

        // Fresh encrypt block after the reset completes normally
        for (int c = 0; c <= 53; c++) cyc("after_rst", c, c == 0, 1'b0, 1'b0, 1'b0, 1'b0, c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
